mbf_stream_merger: RTL and testbench

- Sink-side companion to the MBF filter bank. It consumes the two free-running output streams: the LPF stream (y/y_valid) and the HPF stream (z/z_valid).
- Each stream is buffered in its own FIFO. The block re-emits the samples as a single interleaved stream with a valid/ready handshake, in pair order: y[0], z[0], y[1], z[1], ...
- It feeds the result dump/DMA path, tags each word with its band and pair index, and flags lost samples.

---
 rtl/mbf_stream_merger.sv | 109 ++++++++++
 tb/tb_mbf_stream_merger.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mbf_stream_merger.sv
// mbf_stream_merger: buffers the LPF/HPF sample streams and re-emits them interleaved as y[k], z[k] pairs
module mbf_stream_merger_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  // storage is not reset; the pointers and count define what is valid
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointer and occupancy bookkeeping; a simultaneous write and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  assign head  = mem[rp];
  assign empty = cnt == '0;
  assign full  = cnt == (AW+1)'(DEPTH);
endmodule

module mbf_stream_merger #(
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int N_PAIRS = 527,
  parameter int IW      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          y_valid,
  input  logic [DW-1:0] y,
  input  logic          z_valid,
  input  logic [DW-1:0] z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  output logic [IW-1:0] out_idx,
  output logic          overflow,
  output logic          done
);
  localparam logic [1:0] S_LPF  = 2'd0;
  localparam logic [1:0] S_HPF  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]    state;
  logic [IW-1:0] pair_cnt;
  logic [IW:0]   nxt_cnt;
  logic [DW-1:0] y_head, z_head;
  logic          y_empty, z_empty, y_full, z_full;
  logic          live, xfer, y_pop, z_pop, y_wr, z_wr, y_drop, z_drop, last;
  mbf_stream_merger_fifo #(.DW(DW), .DEPTH(DEPTH)) u_y_fifo (
    .clk(clk), .reset(reset), .wr(y_wr), .din(y), .pop(y_pop),
    .head(y_head), .empty(y_empty), .full(y_full)
  );
  mbf_stream_merger_fifo #(.DW(DW), .DEPTH(DEPTH)) u_z_fifo (
    .clk(clk), .reset(reset), .wr(z_wr), .din(z), .pop(z_pop),
    .head(z_head), .empty(z_empty), .full(z_full)
  );
  // output word, handshake and FIFO write/drop decisions; inputs are ignored once done
  always_comb begin
    live      = state != S_DONE;
    out_sel   = state == S_HPF;
    out_valid = state == S_LPF ? !y_empty : state == S_HPF ? !z_empty : 1'b0;
    out_data  = out_valid ? (out_sel ? z_head : y_head) : '0;
    out_idx   = pair_cnt;
    done      = state == S_DONE;
    xfer      = out_valid & out_ready;
    y_pop     = xfer & !out_sel;
    z_pop     = xfer & out_sel;
    y_wr      = live & y_valid & (!y_full | y_pop);
    z_wr      = live & z_valid & (!z_full | z_pop);
    y_drop    = live & y_valid & y_full & !y_pop;
    z_drop    = live & z_valid & z_full & !z_pop;
    nxt_cnt   = {1'b0, pair_cnt} + (IW+1)'(1);
    last      = nxt_cnt == (IW+1)'(N_PAIRS);
  end
  // band sequencing, pair counting and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LPF;
      pair_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (y_drop | z_drop) overflow <= 1'b1;
      if (y_pop) state <= S_HPF;
      if (z_pop) begin
        pair_cnt <= nxt_cnt[IW-1:0];
        state    <= last ? S_DONE : S_LPF;
      end
    end
  end
endmodule

// File: tb/tb_mbf_stream_merger.sv
// tb_mbf_stream_merger: directed and random checks of the merger against a queue-based reference model
module tb_mbf_stream_merger;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int N_PAIRS = 6;
  localparam int IW      = 3;
  logic          clk = 1'b0;
  logic          reset, y_valid, z_valid, out_ready;
  logic [DW-1:0] y, z;
  logic          out_valid, out_sel, overflow, done;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  int            checks = 0;
  int            errors = 0;
  int            dut_xfers = 0;
  logic [DW-1:0] yq[$];
  logic [DW-1:0] zq[$];
  int            t;
  bit            m_ovf;
  mbf_stream_merger #(.DW(DW), .DEPTH(DEPTH), .N_PAIRS(N_PAIRS), .IW(IW)) dut (
    .clk(clk), .reset(reset), .y_valid(y_valid), .y(y), .z_valid(z_valid), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_idx(out_idx), .overflow(overflow), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_done();
    return t == 2 * N_PAIRS;
  endfunction
  function automatic bit m_valid();
    if (m_done()) return 1'b0;
    return (t % 2 == 0) ? yq.size() > 0 : zq.size() > 0;
  endfunction
  task automatic check_outputs();
    bit v;
    v = m_valid();
    check("out_valid", out_valid, v);
    check("out_data", out_data, v ? ((t % 2 == 0) ? yq[0] : zq[0]) : '0);
    check("out_sel", out_sel, t % 2);
    check("out_idx", out_idx, t / 2);
    check("overflow", overflow, m_ovf);
    check("done", done, m_done());
  endtask
  task automatic model_reset();
    yq.delete();
    zq.delete();
    t = 0;
    m_ovf = 1'b0;
  endtask
  task automatic model_update();
    bit d, v;
    if (reset) begin
      model_reset();
      return;
    end
    d = m_done();
    v = m_valid();
    if (v && out_ready) begin
      if (t % 2 == 0) void'(yq.pop_front());
      else void'(zq.pop_front());
      t++;
    end
    if (!d && y_valid) begin
      if (yq.size() < DEPTH) yq.push_back(y);
      else m_ovf = 1'b1;
    end
    if (!d && z_valid) begin
      if (zq.size() < DEPTH) zq.push_back(z);
      else m_ovf = 1'b1;
    end
  endtask
  task automatic cycle(input bit rst, input bit yv, input logic [DW-1:0] yd,
                       input bit zv, input logic [DW-1:0] zd, input bit rdy);
    reset = rst; y_valid = yv; y = yd; z_valid = zv; z = zd; out_ready = rdy;
    #1;
    check_outputs();
    if (out_valid && out_ready) dut_xfers++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, rdy);
  endtask
  task automatic do_reset();
    cycle(1, 0, '0, 0, '0, 1);
  endtask
  initial begin
    reset = 1'b1; y_valid = 0; z_valid = 0; y = '0; z = '0; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);
    check("rst_sel", out_sel, 0);
    // basic order
    idle(1, 1);
    cycle(0, 1, 8'h11, 0, '0, 1);
    check("t1_y0", out_data, 8'h11);
    idle(1, 1);
    cycle(0, 0, '0, 1, 8'h22, 1);
    check("t1_z0", out_data, 8'h22);
    check("t1_sel", out_sel, 1);
    idle(3, 1);
    // HPF runs ahead
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, DW'(8'hA0 + i), 1);
    idle(3, 1);
    check("t2_wait", out_valid, 0);
    cycle(0, 1, 8'h50, 0, '0, 1);
    cycle(0, 1, 8'h51, 0, '0, 1);
    idle(6, 1);
    check("t2_idx", out_idx, 2);
    // backpressure and overflow
    do_reset();
    for (int i = 0; i <= DEPTH; i++) cycle(0, 1, DW'(i), 0, '0, 0);
    check("t3_ovf", overflow, 1);
    check("t3_head", out_data, 8'h00);
    idle(2, 0);
    for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 0, '0, 1, DW'(8'hC0 + i), 1);
    idle(4, 1);
    // full LPF FIFO with a same-cycle pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, DW'(8'h60 + i), 0, '0, 0);
    cycle(0, 1, 8'hEE, 0, '0, 1);
    check("t4_ovf", overflow, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(0, 0, '0, 1, DW'(8'hD0 + i), 1);
      cycle(0, 0, '0, 0, '0, 1);
    end
    idle(4, 1);
    // termination after N_PAIRS pairs
    do_reset();
    dut_xfers = 0;
    for (int i = 0; i <= N_PAIRS; i++) begin
      cycle(0, 1, DW'(8'h10 + i), 1, DW'(8'h90 + i), 1);
      cycle(0, 0, '0, 0, '0, 1);
    end
    idle(8, 1);
    check("t5_xfers", dut_xfers, 2 * N_PAIRS);
    check("t5_done", done, 1);
    check("t5_ovf", overflow, 0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 8'h77, 1, 8'h88, 0);
    check("t5_ignore", overflow, 0);
    // reset mid-stream
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, DW'(8'h40 + i), 0, '0, 0);
    do_reset();
    check("t6_valid", out_valid, 0);
    check("t6_idx", out_idx, 0);
    check("t6_ovf", overflow, 0);
    cycle(0, 1, 8'h33, 1, 8'h44, 1);
    check("t6_y", out_data, 8'h33);
    idle(1, 1);
    check("t6_z", out_data, 8'h44);
    check("t6_zidx", out_idx, 0);
    idle(2, 1);
    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        cycle(0, $urandom_range(0, 99) < 40, DW'($urandom), $urandom_range(0, 99) < 40,
              DW'($urandom), $urandom_range(0, 99) < 70);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
